// File: rtl/trigger_link_pkg.sv
// Shared definitions for the trigger-channel link.
// Used by the command transmitter and the existing receiver.
package trigger_link_pkg;

    localparam logic [15:0] CMD_HEADER    = 16'hC7E5;
    localparam logic [15:0] UPLOAD_HEADER = 16'hE97B;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_GAP     = 3'd3
    } tx_state_e;

    function automatic logic [15:0] swap16(
        input logic [15:0] w,
        input logic        en
    );
        return en ? {w[7:0], w[15:8]} : w;
    endfunction

endpackage

// File: rtl/trigger_cmd_fifo.sv
// Synchronous command FIFO with full/empty/count status.
// Depth must be a power of two so the pointers wrap naturally.
module trigger_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign rdata = r_mem[r_rptr];

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_wptr] <= wdata;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/trigger_cmd_tx.sv
// Trigger-channel command transmitter: buffers (addr, value) commands
// and sends each as a header word followed by a payload word.
module trigger_cmd_tx
    import trigger_link_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 2,
    parameter int BYTE_SWAP  = 1
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_addr,
    input  logic [7:0]  cmd_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [15:0] tx_data,
    output logic        busy,
    output logic [2:0]  STATE,
    output logic [15:0] frames_sent
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic SWAP_EN = (BYTE_SWAP != 0);

    tx_state_e      r_state;
    logic [15:0]    r_hold;
    logic [15:0]    r_tx_data;
    logic           r_tx_valid;
    logic [15:0]    r_frames;
    logic [GW-1:0]  r_gap;

    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic [CW-1:0]  w_count;
    logic [15:0]    w_rdata;

    assign w_push = cmd_valid && !w_full;
    assign w_pop  = (r_state == ST_IDLE) && !w_empty;

    trigger_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .push   (w_push),
        .wdata  ({cmd_addr, cmd_data}),
        .pop    (w_pop),
        .rdata  (w_rdata),
        .full   (w_full),
        .empty  (w_empty),
        .count  (w_count)
    );

    // Words stay registered and untouched until the link takes them.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_hold     <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_frames   <= '0;
            r_gap      <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_hold     <= w_rdata;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= swap16(CMD_HEADER, SWAP_EN);
                        r_state    <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (tx_ready) begin
                        r_tx_data <= swap16(r_hold, SWAP_EN);
                        r_state   <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_frames   <= r_frames + 16'd1;
                        if (GAP_CYCLES == 0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_gap   <= GAP_LOAD;
                            r_state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap == '0) r_state <= ST_IDLE;
                    else             r_gap   <= r_gap - 1'b1;
                end
                default: begin
                    r_tx_valid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = !w_full;
    assign tx_valid    = r_tx_valid;
    assign tx_data     = r_tx_data;
    assign busy        = (w_count != '0) || (r_state != ST_IDLE);
    assign STATE       = r_state;
    assign frames_sent = r_frames;

endmodule

// File: tb/tb_trigger_cmd_tx.sv
// Directed bench for trigger_cmd_tx: table of frames plus
// hand-written timing, backpressure, fill, reset and loopback cases.
module tb_trigger_cmd_tx;

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  data;
        int          hold;
        logic [15:0] exp_hdr;
        logic [15:0] exp_pl;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic        tx_ready;
    logic        cmd_ready;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        busy;
    logic [2:0]  state;
    logic [15:0] frames;

    logic        b_cmd_valid;
    logic [7:0]  b_cmd_addr;
    logic [7:0]  b_cmd_data;
    logic        b_tx_ready;
    logic        b_cmd_ready;
    logic        b_tx_valid;
    logic [15:0] b_tx_data;
    logic        b_busy;
    logic [2:0]  b_state;
    logic [15:0] b_frames;

    int n_vec = 0;
    int n_err = 0;

    logic        rx_hdr_seen;
    logic [15:0] rx_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    trigger_cmd_tx #(
        .FIFO_DEPTH (4),
        .GAP_CYCLES (2),
        .BYTE_SWAP  (1)
    ) dut (
        .clk_in      (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .tx_ready    (tx_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .busy        (busy),
        .STATE       (state),
        .frames_sent (frames)
    );

    trigger_cmd_tx #(
        .FIFO_DEPTH (4),
        .GAP_CYCLES (0),
        .BYTE_SWAP  (0)
    ) dut_ns (
        .clk_in      (clk),
        .rst_n       (rst_n),
        .cmd_valid   (b_cmd_valid),
        .cmd_ready   (b_cmd_ready),
        .cmd_addr    (b_cmd_addr),
        .cmd_data    (b_cmd_data),
        .tx_ready    (b_tx_ready),
        .tx_valid    (b_tx_valid),
        .tx_data     (b_tx_data),
        .busy        (b_busy),
        .STATE       (b_state),
        .frames_sent (b_frames)
    );

    // Trigger-channel receiver model, endpoint address 0x07.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_hdr_seen <= 1'b0;
            rx_out      <= '0;
        end else if (tx_valid && tx_ready) begin
            if (rx_hdr_seen) begin
                rx_hdr_seen <= 1'b0;
                if (tx_data[7:0] == 8'h07) rx_out <= {8'h00, tx_data[15:8]};
            end else if ({tx_data[7:0], tx_data[15:8]} == 16'hC7E5) begin
                rx_hdr_seen <= 1'b1;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            if (!busy) done = 1;
            else @(negedge clk);
        end
        check("idle", 32'(busy), 32'd0);
    endtask

    task automatic send_frame(input vec_t v);
        int  fr0;
        bit  seen;
        fr0 = int'(frames);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = v.addr;
        cmd_data  = v.data;
        tx_ready  = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (tx_valid) seen = 1;
            else @(negedge clk);
        end
        check("hdr_seen", 32'(seen), 32'd1);
        check("hdr", 32'(tx_data), 32'(v.exp_hdr));
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            check("hdr_hold", {15'd0, tx_valid, tx_data},
                  {15'd0, 1'b1, v.exp_hdr});
        end
        tx_ready = 1'b1;
        @(negedge clk);
        check("payload", {15'd0, tx_valid, tx_data},
              {15'd0, 1'b1, v.exp_pl});
        @(negedge clk);
        check("frame_end", 32'(tx_valid), 32'd0);
        check("frames", 32'(frames), 32'(fr0 + 1));
        wait_idle();
    endtask

    vec_t        tbl [4];
    logic [15:0] got [$];
    logic [15:0] exp_words [10];
    bit          found;
    int          fr_base;

    initial begin
        tbl[0] = '{8'h12, 8'h34, 0, 16'hE5C7, 16'h3412};
        tbl[1] = '{8'h05, 8'hAA, 5, 16'hE5C7, 16'hAA05};
        tbl[2] = '{8'hFF, 8'h00, 2, 16'hE5C7, 16'h00FF};
        tbl[3] = '{8'hC7, 8'h01, 1, 16'hE5C7, 16'h01C7};

        rst_n = 1'b0;
        cmd_valid = 0; cmd_addr = 0; cmd_data = 0; tx_ready = 0;
        b_cmd_valid = 0; b_cmd_addr = 0; b_cmd_data = 0; b_tx_ready = 1;
        #12;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_frames", 32'(frames), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Exact cycle timing with tx_ready held high.
        @(negedge clk);
        cmd_valid = 1; cmd_addr = 8'h12; cmd_data = 8'h34; tx_ready = 1;
        @(negedge clk);
        cmd_valid = 0;
        check("t1_valid", 32'(tx_valid), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t2_word", {15'd0, tx_valid, tx_data}, {15'd0, 17'h1E5C7});
        check("t2_state", 32'(state), 32'd1);
        @(negedge clk);
        check("t3_word", {15'd0, tx_valid, tx_data}, {15'd0, 17'h13412});
        check("t3_state", 32'(state), 32'd2);
        @(negedge clk);
        check("t4_valid", 32'(tx_valid), 32'd0);
        check("t4_frames", 32'(frames), 32'd1);
        check("t4_state", 32'(state), 32'd3);
        @(negedge clk);
        check("t5_valid", 32'(tx_valid), 32'd0);
        check("t5_state", 32'(state), 32'd3);
        @(negedge clk);
        check("t6_state", 32'(state), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 4; i++) send_frame(tbl[i]);

        // Fill: 4 in the FIFO plus 1 in the holding register.
        fr_base = int'(frames);
        tx_ready = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("fill_ready", 32'(cmd_ready), 32'd1);
            cmd_valid = 1;
            cmd_addr  = 8'((k + 1) * 16);
            cmd_data  = 8'(k + 1);
            exp_words[2*k]   = 16'hE5C7;
            exp_words[2*k+1] = {8'(k + 1), 8'((k + 1) * 16)};
        end
        @(negedge clk);
        cmd_valid = 0;
        check("fill_full", 32'(cmd_ready), 32'd0);
        tx_ready = 1;
        got.delete();
        for (int i = 0; i < 100 && got.size() < 10; i++) begin
            if (tx_valid) got.push_back(tx_data);
            @(negedge clk);
        end
        check("fill_count", 32'(got.size()), 32'd10);
        for (int i = 0; i < 10; i++)
            check("fill_word",
                  32'((i < got.size()) ? got[i] : 16'hxxxx),
                  32'(exp_words[i]));
        wait_idle();
        check("fill_frames", 32'(frames), 32'(fr_base + 5));

        // Reset during PAYLOAD with another command queued.
        tx_ready = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_addr = 8'hAA; cmd_data = 8'hBB;
        @(negedge clk);
        cmd_addr = 8'hCC; cmd_data = 8'hDD;
        @(negedge clk);
        cmd_valid = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (state == 3'd1) found = 1;
            else @(negedge clk);
        end
        tx_ready = 1;
        @(negedge clk);
        tx_ready = 0;
        check("pre_rst_state", 32'(state), 32'd2);
        rst_n = 0;
        #1;
        check("mid_rst_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_frames", 32'(frames), 32'd0);
        check("mid_rst_state", 32'(state), 32'd0);
        @(negedge clk);
        rst_n = 1;
        send_frame(tbl[0]);

        // No swap, no gap instance.
        @(negedge clk);
        b_cmd_valid = 1; b_cmd_addr = 8'h01; b_cmd_data = 8'hFF;
        @(negedge clk);
        b_cmd_valid = 0;
        @(negedge clk);
        check("ns_hdr", {15'd0, b_tx_valid, b_tx_data}, {15'd0, 17'h1C7E5});
        @(negedge clk);
        check("ns_payload", {15'd0, b_tx_valid, b_tx_data},
              {15'd0, 17'h101FF});
        @(negedge clk);
        check("ns_idle_state", 32'(b_state), 32'd0);
        check("ns_valid", 32'(b_tx_valid), 32'd0);
        check("ns_frames", 32'(b_frames), 32'd1);

        // Loopback into the receiver model.
        send_frame('{8'h07, 8'h5A, 0, 16'hE5C7, 16'h5A07});
        check("rx_first", 32'(rx_out), 32'h005A);
        send_frame('{8'h08, 8'h11, 0, 16'hE5C7, 16'h1108});
        check("rx_other_ep", 32'(rx_out), 32'h005A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
